// File: rtl/modexp_param.sv
// Modular exponentiation x^exponent mod modulus with left-to-right square-and-multiply in the Montgomery domain.
// Optional build macro MODEXP_CONST_TIME_EN gives a fixed, exponent-independent latency.
module modexp_param #(
    parameter int WIDTH     = 512,
    parameter int EXP_WIDTH = 512
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     modulus,
    input  logic [EXP_WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0]     Rmodm,
    input  logic [WIDTH-1:0]     Rsquaredmodm,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SCAN, S_PRE, S_SQR, S_MUL, S_POST, S_DONE
    } state_t;

    state_t                 state_r, state_s;
    logic [WIDTH-1:0]       x_r, m_r, r1_r, r2_r, a_r, xt_r, result_r;
    logic [EXP_WIDTH-1:0]   e_r;
    logic [WIDTH+1:0]       t_r;
    logic [CW-1:0]          cnt_r;
    logic [IW-1:0]          bit_r;
    logic                   busy_r, done_r;

    logic [WIDTH-1:0]       op_a_s, op_b_s, res_s;
    logic [WIDTH+1:0]       t_cur_s, step_s;
    logic [IW-1:0]          bit_m1_s;
    logic                   mm_act_s, mm_last_s, a_bit_s, cur_bit_s, bit_dec_s, mul_keep_s;

    // One radix-2 Montgomery iteration: (t + a_j*b + q*m) / 2 with q chosen to make the sum even.
    function automatic logic [WIDTH+1:0] mont_step(
        input logic [WIDTH+1:0] t,
        input logic             a_bit,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] m
    );
        logic [WIDTH+1:0] s;
        if (a_bit) begin
            s = t + {2'b00, b};
        end else begin
            s = t;
        end
        if (s[0]) begin
            s = s + {2'b00, m};
        end else begin
            s = s;
        end
        return s >> 1;
    endfunction

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

    assign bit_m1_s  = bit_r - IW'(1);
    assign cur_bit_s = e_r[bit_r];
    assign mm_act_s  = (state_r == S_PRE) || (state_r == S_SQR) ||
                       (state_r == S_MUL) || (state_r == S_POST);
    assign mm_last_s = mm_act_s && (cnt_r == CW'(WIDTH));

`ifdef MODEXP_CONST_TIME_EN
    assign mul_keep_s = cur_bit_s;
`else
    assign mul_keep_s = 1'b1;
`endif

    // Multiplier operand selection, iteration step and final conditional subtract
    always_comb begin
        op_a_s = '0;
        op_b_s = '0;
        case (state_r)
            S_PRE: begin
                op_a_s = x_r;
                op_b_s = r2_r;
            end
            S_SQR: begin
                op_a_s = a_r;
                op_b_s = a_r;
            end
            S_MUL: begin
                op_a_s = a_r;
                op_b_s = xt_r;
            end
            S_POST: begin
                op_a_s = a_r;
                op_b_s = WIDTH'(1);
            end
            default: begin
                op_a_s = '0;
                op_b_s = '0;
            end
        endcase
        a_bit_s = op_a_s[cnt_r[AW-1:0]];
        if (cnt_r == CW'(0)) begin
            t_cur_s = '0;
        end else begin
            t_cur_s = t_r;
        end
        step_s = mont_step(t_cur_s, a_bit_s, op_b_s, m_r);
        if (t_r >= {2'b00, m_r}) begin
            res_s = WIDTH'(t_r - {2'b00, m_r});
        end else begin
            res_s = t_r[WIDTH-1:0];
        end
    end

    // Next-state logic and exponent bit-pointer decrement requests
    always_comb begin
        state_s   = state_r;
        bit_dec_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s = S_LOAD;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD: begin
`ifdef MODEXP_CONST_TIME_EN
                state_s = S_PRE;
`else
                if (e_r[EXP_WIDTH-1] || (EXP_WIDTH == 1)) begin
                    state_s = S_PRE;
                end else begin
                    state_s = S_SCAN;
                end
`endif
            end
            S_SCAN: begin
                // Look one bit ahead so the cycle that finds the leading one also leaves SCAN.
                bit_dec_s = 1'b1;
                if (e_r[bit_m1_s] || (bit_r == IW'(1))) begin
                    state_s = S_PRE;
                end else begin
                    state_s = S_SCAN;
                end
            end
            S_PRE: begin
                if (mm_last_s) begin
`ifdef MODEXP_CONST_TIME_EN
                    state_s = S_SQR;
`else
                    if (cur_bit_s) begin
                        state_s = S_SQR;
                    end else begin
                        state_s = S_POST;
                    end
`endif
                end else begin
                    state_s = S_PRE;
                end
            end
            S_SQR: begin
                if (mm_last_s) begin
`ifdef MODEXP_CONST_TIME_EN
                    state_s = S_MUL;
`else
                    if (cur_bit_s) begin
                        state_s = S_MUL;
                    end else if (bit_r == IW'(0)) begin
                        state_s = S_POST;
                    end else begin
                        state_s   = S_SQR;
                        bit_dec_s = 1'b1;
                    end
`endif
                end else begin
                    state_s = S_SQR;
                end
            end
            S_MUL: begin
                if (mm_last_s) begin
                    if (bit_r == IW'(0)) begin
                        state_s = S_POST;
                    end else begin
                        state_s   = S_SQR;
                        bit_dec_s = 1'b1;
                    end
                end else begin
                    state_s = S_MUL;
                end
            end
            S_POST: begin
                if (mm_last_s) begin
                    state_s = S_DONE;
                end else begin
                    state_s = S_POST;
                end
            end
            S_DONE: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand latches, Montgomery accumulator, exponent pointer and handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_r      <= '0;
            m_r      <= '0;
            e_r      <= '0;
            r1_r     <= '0;
            r2_r     <= '0;
            a_r      <= '0;
            xt_r     <= '0;
            t_r      <= '0;
            cnt_r    <= '0;
            bit_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
        end else begin
            // Operands are captured at the accepting edge so callers may release them right away.
            if ((state_r == S_IDLE) && start) begin
                x_r    <= x;
                m_r    <= modulus;
                e_r    <= exponent;
                r1_r   <= Rmodm;
                r2_r   <= Rsquaredmodm;
                busy_r <= 1'b1;
            end
            if (state_r == S_LOAD) begin
                a_r   <= r1_r;
                bit_r <= IW'(EXP_WIDTH - 1);
            end
            if (bit_dec_s) begin
                bit_r <= bit_m1_s;
            end
            if (mm_act_s && !mm_last_s) begin
                t_r   <= step_s;
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= '0;
            end
            if (mm_last_s) begin
                case (state_r)
                    S_PRE: xt_r <= res_s;
                    S_SQR: a_r <= res_s;
                    S_MUL: begin
                        if (mul_keep_s) begin
                            a_r <= res_s;
                        end
                    end
                    S_POST: begin
                        a_r      <= res_s;
                        result_r <= res_s;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                    end
                    default: begin
                    end
                endcase
            end
            if (state_r == S_DONE) begin
                done_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_modexp_param.sv
// Directed bench for modexp_param: an 8-bit instance for functional and timing cases,
// plus the 512-bit reference vector (normal build only, the constant-time run is too long).
module tb_modexp_param;

`ifdef MODEXP_CONST_TIME_EN
    localparam bit CT = 1'b1;
`else
    localparam bit CT = 1'b0;
`endif
    localparam int CT_LAT8 = 163;

    logic         clk = 1'b0;
    logic         reset;
    logic         start8, busy8, done8;
    logic [7:0]   x8, m8, e8, rm8, r28, res8;
    logic         start_b, busy_b, done_b;
    logic [511:0] x_b, m_b, e_b, rm_b, r2_b, res_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    modexp_param #(.WIDTH(8), .EXP_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .x(x8), .modulus(m8), .exponent(e8),
        .Rmodm(rm8), .Rsquaredmodm(r28), .busy(busy8), .done(done8), .result(res8)
    );

    modexp_param #(.WIDTH(512), .EXP_WIDTH(512)) dut512 (
        .clk(clk), .reset(reset), .start(start_b), .x(x_b), .modulus(m_b), .exponent(e_b),
        .Rmodm(rm_b), .Rsquaredmodm(r2_b), .busy(busy_b), .done(done_b), .result(res_b)
    );

    task automatic launch8(input logic [7:0] xi, mi, ei, rmi, r2i);
        @(negedge clk);
        while (done8) @(negedge clk);
        x8 = xi; m8 = mi; e8 = ei; rm8 = rmi; r28 = r2i;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
    endtask

    task automatic wait_done8(input int from, input int limit, output int cyc);
        int c;
        c   = from;
        cyc = -1;
        while (c < limit) begin
            @(posedge clk);
            c++;
            #1;
            if (done8) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #3;
        n_tests++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy8: got %b expected 0", busy8); end
        n_tests++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done8: got %b expected 0", done8); end
        n_tests++; if (res8 !== 8'd0) begin n_fail++; $display("FAIL reset_result8: got %0d expected 0", res8); end
        n_tests++; if (busy_b !== 1'b0 || done_b !== 1'b0 || res_b !== 512'd0) begin
            n_fail++; $display("FAIL reset_512: busy %b done %b result %h, expected all zero", busy_b, done_b, res_b);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int cyc;
        launch8(8'd5, 8'd13, 8'd3, 8'd9, 8'd3);
        n_tests++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %b expected 1", busy8); end
        wait_done8(0, 400, cyc);
        n_tests++; if (res8 !== 8'd8) begin n_fail++; $display("FAIL basic_result: got %0d expected 8", res8); end
        n_tests++; if (cyc != (CT ? CT_LAT8 : 61)) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", cyc, CT ? CT_LAT8 : 61); end
        n_tests++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL basic_busy_fall: got %b expected 0", busy8); end
        @(posedge clk);
        #1;
        n_tests++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b expected 0", done8); end
        n_tests++; if (res8 !== 8'd8) begin n_fail++; $display("FAIL basic_result_held: got %0d expected 8", res8); end
    endtask

    task automatic test_patterns;
        logic [7:0] tx [4]  = '{8'd5, 8'd5, 8'd5, 8'd7};
        logic [7:0] tm [4]  = '{8'd13, 8'd13, 8'd13, 8'd11};
        logic [7:0] te [4]  = '{8'h01, 8'hFF, 8'h80, 8'h0B};
        logic [7:0] tr1 [4] = '{8'd9, 8'd9, 8'd9, 8'd3};
        logic [7:0] tr2 [4] = '{8'd3, 8'd3, 8'd3, 8'd9};
        logic [7:0] tres [4] = '{8'd5, 8'd8, 8'd1, 8'd7};
        int         tlat [4] = '{44, 163, 100, 86};
        int cyc;
        for (int k = 0; k < 4; k++) begin
            launch8(tx[k], tm[k], te[k], tr1[k], tr2[k]);
            wait_done8(0, 400, cyc);
            n_tests++; if (res8 !== tres[k]) begin n_fail++; $display("FAIL pattern%0d_result: got %0d expected %0d", k, res8, tres[k]); end
            n_tests++; if (cyc != (CT ? CT_LAT8 : tlat[k])) begin
                n_fail++; $display("FAIL pattern%0d_latency: got %0d expected %0d", k, cyc, CT ? CT_LAT8 : tlat[k]);
            end
        end
    endtask

    task automatic test_zero_exp;
        int cyc;
        launch8(8'd5, 8'd13, 8'd0, 8'd9, 8'd3);
        wait_done8(0, 400, cyc);
        n_tests++; if (res8 !== 8'd1) begin n_fail++; $display("FAIL zero_exp_result: got %0d expected 1", res8); end
        n_tests++; if (cyc != (CT ? CT_LAT8 : 26)) begin n_fail++; $display("FAIL zero_exp_latency: got %0d expected %0d", cyc, CT ? CT_LAT8 : 26); end
    endtask

    task automatic test_start_while_busy;
        int cyc;
        launch8(8'd5, 8'd13, 8'd3, 8'd9, 8'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        x8 = 8'd7; m8 = 8'd11; e8 = 8'h0B; rm8 = 8'd3; r28 = 8'd9;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        wait_done8(11, 400, cyc);
        n_tests++; if (res8 !== 8'd8) begin n_fail++; $display("FAIL busy_start_result: got %0d expected 8", res8); end
        n_tests++; if (cyc != (CT ? CT_LAT8 : 61)) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected %0d", cyc, CT ? CT_LAT8 : 61); end
    endtask

    task automatic test_input_change;
        int cyc;
        launch8(8'd5, 8'd13, 8'd3, 8'd9, 8'd3);
        @(posedge clk);
        #1;
        x8 = 8'hAA; e8 = 8'hFF; m8 = 8'h07;
        wait_done8(1, 400, cyc);
        n_tests++; if (res8 !== 8'd8) begin n_fail++; $display("FAIL input_change_result: got %0d expected 8", res8); end
        n_tests++; if (cyc != (CT ? CT_LAT8 : 61)) begin n_fail++; $display("FAIL input_change_latency: got %0d expected %0d", cyc, CT ? CT_LAT8 : 61); end
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        launch8(8'd5, 8'd13, 8'd3, 8'd9, 8'd3);
        repeat (19) @(posedge clk);
        #1;
        n_tests++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %b expected 1", busy8); end
        reset = 1'b1;
        #1;
        n_tests++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy8); end
        n_tests++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", done8); end
        n_tests++; if (res8 !== 8'd0) begin n_fail++; $display("FAIL midreset_result: got %0d expected 0", res8); end
        @(negedge clk);
        reset = 1'b0;
        launch8(8'd5, 8'd13, 8'h80, 8'd9, 8'd3);
        wait_done8(0, 400, cyc);
        n_tests++; if (res8 !== 8'd1) begin n_fail++; $display("FAIL midreset_rerun_result: got %0d expected 1", res8); end
        n_tests++; if (cyc != (CT ? CT_LAT8 : 100)) begin n_fail++; $display("FAIL midreset_rerun_latency: got %0d expected %0d", cyc, CT ? CT_LAT8 : 100); end
    endtask

    task automatic test_full_width;
        logic [511:0] exp_res;
        int c, cyc;
        exp_res = 512'hbdb2a4a461dbff5011756139d13f5446a7eb6c9979b55e8fa687b6edaa842d502fc159a825fe144175f9b5616000e5c971e67f150f5135dd5d6fd220f7400189;
        @(negedge clk);
        m_b  = 512'hd97a21880ab3b85681ef6162732ffcd3cf303982004568f7fba23d0d411ced4080fd567efcd793b308936f7522ead3c53ad80440edd50088935d2a3d9b9c5885;
        x_b  = 512'h87b21d93a10f35511c8d56264a6f95f0245d8004e0d3557c7ec2b396b4ed3cabda34f88e0c8154e9ffab2761e626a720eef1da7ee31ce6c31fcdeaec38eb9589;
        e_b  = 512'haf;
        rm_b = 512'h2685de77f54c47a97e109e9d8cd0032c30cfc67dffba9708045dc2f2bee312bf7f02a98103286c4cf76c908add152c3ac527fbbf122aff776ca2d5c26463a77b;
        r2_b = 512'h733f6233b70f1ff7bc7ea9a38d69c2d083bec7c1d73000a3c36a6b4699300aff43a2c4da76786ac6878e16ad896b861ad351008baa901886630148792eca57ad;
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        c   = 0;
        cyc = -1;
        while (c < 20000) begin
            @(posedge clk);
            c++;
            #1;
            if (done_b) begin
                cyc = c;
                break;
            end
        end
        n_tests++; if (res_b !== exp_res) begin n_fail++; $display("FAIL full_width_result: got %h expected %h", res_b, exp_res); end
        n_tests++; if (cyc != 8713) begin n_fail++; $display("FAIL full_width_latency: got %0d expected 8713", cyc); end
    endtask

    initial begin
        start8 = 1'b0; x8 = '0; m8 = '0; e8 = '0; rm8 = '0; r28 = '0;
        start_b = 1'b0; x_b = '0; m_b = '0; e_b = '0; rm_b = '0; r2_b = '0;
        test_reset;
        test_basic;
        test_patterns;
        test_zero_exp;
        test_start_while_busy;
        test_input_change;
        test_reset_mid_run;
`ifndef MODEXP_CONST_TIME_EN
        test_full_width;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
